// File: rtl/usb_spi_engine.sv
// SPI mode-0 register transaction engine for the USB host-controller chip.
// It first sequences the chip reset, then shifts one command byte plus 0..MAX_BYTES data bytes.
module usb_spi_engine #(
   parameter int CLK_DIV    = 4,
   parameter int MAX_BYTES  = 8,
   parameter int RST_CYCLES = 16,
   localparam int LW        = $clog2(MAX_BYTES + 1)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          req_valid_in,
   output logic          req_ready_out,
   input  logic [4:0]    req_addr_in,
   input  logic          req_write_in,
   input  logic [LW-1:0] req_len_in,
   input  logic [7:0]    wr_data_in,
   input  logic          wr_valid_in,
   output logic          wr_ready_out,
   output logic [7:0]    rd_data_out,
   output logic          rd_valid_out,
   output logic [7:0]    status_out,
   output logic          done_out,
   input  logic          int_in,
   output logic          int_out,
   input  logic          miso_in,
   output logic          rst_out,
   output logic          ss_out,
   output logic          sclk_out,
   output logic          mosi_out
);
   localparam int CMAX = (RST_CYCLES > CLK_DIV + 1) ? RST_CYCLES : CLK_DIV + 1;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CLK_DIV);
   localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_BYTES);

   typedef enum logic [2:0] {
      RST_HOLD = 3'd0,
      IDLE     = 3'd1,
      SETUP    = 3'd2,
      SHIFT    = 3'd3,
      STALL    = 3'd4,
      HOLD     = 3'd5,
      GAP      = 3'd6
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic [2:0]    bit_cnt_r;
   logic [LW-1:0] byte_cnt_r;
   logic [LW-1:0] len_r;
   logic          write_r;
   logic [7:0]    tx_sr_r;
   logic [6:0]    rx_sr_r;
   logic [7:0]    rx_byte_s;
   logic          rst_out_r, ss_r, sclk_r, ready_r;
   logic          wr_ready_r, rd_valid_r, done_r;
   logic [7:0]    rd_data_r, status_r;
   logic          int_meta_r, int_sync_r, int_r;

   // Byte as it stands once the bit on MISO at this rising edge is included.
   always_comb begin
      rx_byte_s = {rx_sr_r, miso_in};
   end

   // Transaction sequencer: reset hold, command/data shifting, write-data stalls.
   always_ff @(posedge clk_in) begin
      wr_ready_r <= 1'b0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      if (rst_in) begin
         state_r    <= RST_HOLD;
         cnt_r      <= '0;
         bit_cnt_r  <= 3'd0;
         byte_cnt_r <= '0;
         len_r      <= '0;
         write_r    <= 1'b0;
         tx_sr_r    <= 8'h00;
         rx_sr_r    <= 7'h00;
         rst_out_r  <= 1'b1;
         ss_r       <= 1'b1;
         sclk_r     <= 1'b0;
         ready_r    <= 1'b0;
         rd_data_r  <= 8'h00;
         status_r   <= 8'h00;
      end else begin
         case (state_r)
            RST_HOLD: begin
               if (cnt_r == RST_LAST) begin
                  cnt_r     <= '0;
                  rst_out_r <= 1'b0;
                  ready_r   <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            IDLE: begin
               if (req_valid_in && ready_r) begin
                  write_r    <= req_write_in;
                  len_r      <= (req_len_in > LEN_MAX) ? LEN_MAX : req_len_in;
                  tx_sr_r    <= {req_addr_in, 1'b0, req_write_in, 1'b0};
                  ss_r       <= 1'b0;
                  ready_r    <= 1'b0;
                  cnt_r      <= '0;
                  bit_cnt_r  <= 3'd0;
                  byte_cnt_r <= '0;
                  state_r    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r   <= '0;
                  state_r <= SHIFT;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            SHIFT: begin
               if (cnt_r != HALF_LAST) begin
                  cnt_r <= cnt_r + CW'(1);
               end else if (!sclk_r) begin
                  cnt_r   <= '0;
                  sclk_r  <= 1'b1;
                  rx_sr_r <= rx_byte_s[6:0];
                  if (bit_cnt_r == 3'd7) begin
                     if (byte_cnt_r == '0) begin
                        status_r <= rx_byte_s;
                     end else if (!write_r) begin
                        rd_data_r  <= rx_byte_s;
                        rd_valid_r <= 1'b1;
                     end
                  end
               end else begin
                  cnt_r  <= '0;
                  sclk_r <= 1'b0;
                  if (bit_cnt_r != 3'd7) begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                     tx_sr_r   <= {tx_sr_r[6:0], 1'b0};
                  end else begin
                     // Byte boundary: finish, send a read filler, or fetch the next write byte.
                     bit_cnt_r <= 3'd0;
                     if (byte_cnt_r == len_r) begin
                        tx_sr_r <= 8'h00;
                        state_r <= HOLD;
                     end else if (!write_r) begin
                        tx_sr_r    <= 8'h00;
                        byte_cnt_r <= byte_cnt_r + LW'(1);
                     end else if (wr_valid_in) begin
                        tx_sr_r    <= wr_data_in;
                        wr_ready_r <= 1'b1;
                        byte_cnt_r <= byte_cnt_r + LW'(1);
                     end else begin
                        state_r <= STALL;
                     end
                  end
               end
            end
            STALL: begin
               if (wr_valid_in) begin
                  tx_sr_r    <= wr_data_in;
                  wr_ready_r <= 1'b1;
                  byte_cnt_r <= byte_cnt_r + LW'(1);
                  cnt_r      <= '0;
                  state_r    <= SHIFT;
               end
            end
            HOLD: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r   <= '0;
                  ss_r    <= 1'b1;
                  done_r  <= 1'b1;
                  state_r <= GAP;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            GAP: begin
               if (cnt_r == GAP_LAST) begin
                  cnt_r   <= '0;
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r <= RST_HOLD;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Interrupt synchroniser; the idle line level is high.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         int_meta_r <= 1'b1;
         int_sync_r <= 1'b1;
         int_r      <= 1'b0;
      end else begin
         int_meta_r <= int_in;
         int_sync_r <= int_meta_r;
         int_r      <= ~int_sync_r;
      end
   end

   assign req_ready_out = ready_r;
   assign wr_ready_out  = wr_ready_r;
   assign rd_data_out   = rd_data_r;
   assign rd_valid_out  = rd_valid_r;
   assign status_out    = status_r;
   assign done_out      = done_r;
   assign int_out       = int_r;
   assign rst_out       = rst_out_r;
   assign ss_out        = ss_r;
   assign sclk_out      = sclk_r;
   assign mosi_out      = tx_sr_r[7];
endmodule

// File: tb/tb_usb_spi_engine.sv
// Self-checking bench for usb_spi_engine: an SPI chip model plus a transaction-level
// reference (byte lists and closed-form latencies) driven by directed and random requests.
module tb_usb_spi_engine;
   localparam int CLK_DIV    = 4;
   localparam int MAX_BYTES  = 8;
   localparam int RST_CYCLES = 16;

   logic       clk_in = 1'b0;
   logic       rst_in, req_valid_in, req_write_in, wr_valid_in, int_in, miso_in;
   logic [4:0] req_addr_in;
   logic [3:0] req_len_in;
   logic [7:0] wr_data_in, rd_data_out, status_out;
   logic       req_ready_out, wr_ready_out, rd_valid_out, done_out, int_out;
   logic       rst_out, ss_out, sclk_out, mosi_out;

   usb_spi_engine #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .RST_CYCLES(RST_CYCLES)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_addr_in(req_addr_in), .req_write_in(req_write_in), .req_len_in(req_len_in),
      .wr_data_in(wr_data_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
      .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .status_out(status_out),
      .done_out(done_out), .int_in(int_in), .int_out(int_out), .miso_in(miso_in),
      .rst_out(rst_out), .ss_out(ss_out), .sclk_out(sclk_out), .mosi_out(mosi_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] chip_q[$];
   logic [7:0] wr_q[$];
   logic [7:0] mosi_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] mosi_acc;
   int rise_cnt, fall_cnt, wr_ready_cnt, done_cnt, idle_viol, ss_rise_cyc, acc_cyc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic chip_bit(input int idx);
      logic [7:0] b;
      if (idx / 8 >= chip_q.size()) return 1'b0;
      b = chip_q[idx / 8];
      return b[7 - (idx % 8)];
   endfunction

   // Chip model and bus monitor, sampled mid-cycle.
   initial begin
      logic ss_prev, sclk_prev;
      ss_prev = 1'b1; sclk_prev = 1'b0; miso_in = 1'b0;
      rise_cnt = 0; fall_cnt = 0; wr_ready_cnt = 0; done_cnt = 0; idle_viol = 0;
      ss_rise_cyc = -1; mosi_acc = 8'h00;
      forever begin
         @(negedge clk_in);
         if (ss_out === 1'b0 && ss_prev === 1'b1) begin
            rise_cnt = 0; fall_cnt = 0; wr_ready_cnt = 0; done_cnt = 0;
            mosi_q.delete(); rd_q.delete();
            miso_in = chip_bit(0);
         end
         if (sclk_out === 1'b1 && sclk_prev === 1'b0) begin
            mosi_acc = {mosi_acc[6:0], mosi_out};
            rise_cnt++;
            if (rise_cnt % 8 == 0) mosi_q.push_back(mosi_acc);
         end
         if (sclk_out === 1'b0 && sclk_prev === 1'b1) begin
            fall_cnt++;
            miso_in = chip_bit(fall_cnt);
         end
         if (sclk_out === 1'b1 && ss_out === 1'b1) idle_viol++;
         if (rd_valid_out === 1'b1) rd_q.push_back(rd_data_out);
         if (wr_ready_out === 1'b1) wr_ready_cnt++;
         if (done_out === 1'b1) done_cnt++;
         if (ss_out === 1'b1 && ss_prev === 1'b0) ss_rise_cyc = cyc;
         ss_prev = ss_out;
         sclk_prev = sclk_out;
      end
   end

   task automatic release_and_count_reset();
      int n_hi = 0;
      int viol = 0;
      rst_in = 1'b0;
      for (int w = 0; w < 100 && rst_out === 1'b1; w++) begin
         n_hi++;
         if (ss_out !== 1'b1 || sclk_out !== 1'b0 || req_ready_out !== 1'b0) viol++;
         @(posedge clk_in); #1;
      end
      check_eq("rst_hold_cycles", n_hi, RST_CYCLES);
      check_eq("rst_idle_lines", viol, 0);
      check_eq("ready_after_rst", req_ready_out, 1'b1);
   endtask

   task automatic start_txn(input logic [4:0] addr, input logic wr, input logic [3:0] len);
      for (int w = 0; w < 2000 && req_ready_out !== 1'b1; w++) begin
         @(posedge clk_in); #1;
      end
      check_eq("ready_wait", req_ready_out, 1'b1);
      req_addr_in = addr; req_write_in = wr; req_len_in = len; req_valid_in = 1'b1;
      acc_cyc = cyc;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      req_addr_in = 5'($urandom); req_len_in = 4'($urandom);
   endtask

   task automatic run_txn(input logic [4:0] addr, input logic wr, input logic [3:0] len,
                          input int stall_idx, input int stall_len);
      int n, exp_lat, lat, gap, done_at, lim;
      logic got_done;
      logic [7:0] exp_mosi[$];
      n = (int'(len) > MAX_BYTES) ? MAX_BYTES : int'(len);
      exp_lat = 1 + CLK_DIV * (2 + 16 * (n + 1)) + ((stall_idx >= 0) ? stall_len + 1 : 0);
      exp_mosi.push_back({addr, 1'b0, wr, 1'b0});
      for (int i = 0; i < n; i++) exp_mosi.push_back(wr ? wr_q[i] : 8'h00);
      lat = -1; gap = -1; done_at = -1; got_done = 1'b0;
      start_txn(addr, wr, len);
      fork
         begin : producer
            if (wr) begin
               for (int i = 0; i < n; i++) begin
                  logic got;
                  if (i == stall_idx) begin
                     wr_valid_in = 1'b0;
                     for (int w = 0; w < 4000 && fall_cnt < 8 * (i + 1); w++) begin
                        @(posedge clk_in); #1;
                     end
                     for (int w = 0; w < stall_len - 1; w++) begin
                        @(posedge clk_in); #1;
                     end
                  end
                  wr_data_in = wr_q[i]; wr_valid_in = 1'b1;
                  got = 1'b0;
                  for (int w = 0; w < 4000 && !got; w++) begin
                     @(posedge clk_in); #1;
                     got = wr_ready_out;
                  end
                  check_eq($sformatf("wr_fetch%0d", i), got, 1'b1);
                  if (!got) break;
               end
            end
            wr_valid_in = 1'b0;
         end
         begin : waiter
            for (int w = 0; w < 4000 && !got_done; w++) begin
               @(posedge clk_in); #1;
               if (done_out === 1'b1) begin
                  got_done = 1'b1; done_at = cyc; lat = cyc - acc_cyc;
               end
            end
            if (got_done) begin
               gap = 0;
               for (int w = 0; w < 50 && req_ready_out !== 1'b1; w++) begin
                  @(posedge clk_in); #1;
                  gap++;
               end
            end
         end
      join
      check_eq("done_seen", got_done, 1'b1);
      check_eq("latency", lat, exp_lat);
      check_eq("ready_gap", gap, CLK_DIV + 1);
      check_eq("rising_edges", rise_cnt, 8 * (n + 1));
      check_eq("mosi_bytes", mosi_q.size(), n + 1);
      lim = (mosi_q.size() < n + 1) ? mosi_q.size() : n + 1;
      for (int k = 0; k < lim; k++) check_eq($sformatf("mosi%0d", k), mosi_q[k], exp_mosi[k]);
      check_eq("status", status_out, chip_q[0]);
      check_eq("rd_count", rd_q.size(), wr ? 0 : n);
      lim = (rd_q.size() < n) ? rd_q.size() : n;
      for (int k = 0; k < lim; k++) check_eq($sformatf("rd%0d", k), rd_q[k], chip_q[k + 1]);
      check_eq("wr_ready_count", wr_ready_cnt, wr ? n : 0);
      check_eq("done_count", done_cnt, 1);
      check_eq("ss_rise_at_done", ss_rise_cyc, done_at);
      check_eq("sclk_idle_low", idle_viol, 0);
   endtask

   task automatic fill_queues(input int n);
      chip_q.delete(); wr_q.delete();
      for (int i = 0; i <= n; i++) chip_q.push_back(8'($urandom));
      for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
   endtask

   initial begin
      int lag;
      rst_in = 1'b1; req_valid_in = 1'b0; req_write_in = 1'b0; req_addr_in = 5'd0;
      req_len_in = 4'd0; wr_valid_in = 1'b0; wr_data_in = 8'h00; int_in = 1'b1;
      @(posedge clk_in); #1;
      check_eq("rst_val_ss", ss_out, 1'b1);
      check_eq("rst_val_sclk", sclk_out, 1'b0);
      check_eq("rst_val_mosi", mosi_out, 1'b0);
      check_eq("rst_val_rst_out", rst_out, 1'b1);
      check_eq("rst_val_pulses", {req_ready_out, wr_ready_out, rd_valid_out, done_out, int_out}, 5'b0);
      check_eq("rst_val_bytes", {status_out, rd_data_out}, 16'h0000);
      @(posedge clk_in); #1;
      release_and_count_reset();

      // Directed transactions.
      chip_q = '{8'hC7, 8'h00}; wr_q = '{8'h91};
      run_txn(5'd17, 1'b1, 4'd1, -1, 0);
      chip_q = '{8'h5C, 8'hA5, 8'h3C}; wr_q.delete();
      run_txn(5'd3, 1'b0, 4'd2, -1, 0);
      chip_q = '{8'h81, 8'h00, 8'h00}; wr_q = '{8'h3C, 8'hE1};
      run_txn(5'd30, 1'b1, 4'd2, 1, 50);
      chip_q = '{8'h6B}; wr_q.delete();
      run_txn(5'd9, 1'b0, 4'd0, -1, 0);
      fill_queues(MAX_BYTES);
      run_txn(5'd21, 1'b0, 4'd13, -1, 0);

      // Reset in the middle of a data byte.
      fill_queues(3);
      start_txn(5'd2, 1'b0, 4'd3);
      for (int w = 0; w < 2000 && rise_cnt < 12; w++) begin
         @(posedge clk_in); #1;
      end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      check_eq("midrst_ss", ss_out, 1'b1);
      check_eq("midrst_sclk", sclk_out, 1'b0);
      check_eq("midrst_rst_out", rst_out, 1'b1);
      release_and_count_reset();
      check_eq("midrst_no_rd", rd_q.size(), 0);
      check_eq("midrst_no_done", done_cnt, 0);
      check_eq("midrst_status", status_out, 8'h00);

      // Random transactions.
      for (int t = 0; t < 14; t++) begin
         logic [4:0] a;
         logic       w;
         logic [3:0] l;
         int n, sidx, slen;
         a = 5'($urandom); w = 1'($urandom);
         l = 4'($urandom_range(0, (t == 0) ? 15 : 9));
         n = (int'(l) > MAX_BYTES) ? MAX_BYTES : int'(l);
         fill_queues(n);
         sidx = -1; slen = 0;
         if (w && n >= 2 && $urandom_range(0, 1) == 1) begin
            sidx = $urandom_range(1, n - 1);
            slen = $urandom_range(1, 20);
         end
         run_txn(a, w, l, sidx, slen);
      end

      // Interrupt synchroniser latency.
      @(posedge clk_in); #1;
      int_in = 1'b0; lag = 0;
      for (int w = 0; w < 10 && int_out !== 1'b1; w++) begin
         @(posedge clk_in); #1; lag++;
      end
      check_eq("int_assert_lag", (lag >= 2 && lag <= 3), 1'b1);
      int_in = 1'b1; lag = 0;
      for (int w = 0; w < 10 && int_out !== 1'b0; w++) begin
         @(posedge clk_in); #1; lag++;
      end
      check_eq("int_release_lag", (lag >= 2 && lag <= 3), 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/usb_spi_engine.md
# usb_spi_engine

Parametrised SPI transaction engine for the USB host-controller interface chip: it sequences the chip's hardware reset, then executes register transactions. Each transaction is one command byte followed by 0..MAX_BYTES data bytes, in SPI mode 0 with a programmable SCLK rate. It replaces fixed-sequence bit-banging in the USB controller: upper-level FSMs issue register reads/writes through a valid/ready request port and stream write/read data bytes. The engine also synchronises the chip's interrupt line and captures the status byte clocked out during every command byte.

## Interface
- CLK_DIV, 4: system clocks per SCLK half-period; ≥2.
- MAX_BYTES, 8: maximum data bytes per transaction; ≥1.
- RST_CYCLES, 16: system clocks rst_out is held after rst_in; ≥1.
- LW = $clog2(MAX_BYTES+1) (localparam).

- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- req_valid_in  in  1  transaction request.
- req_ready_out  out  1  engine idle; request accepted when valid&ready.
- req_addr_in  in  5  chip register number.
- req_write_in  in  1  1 = write transaction, 0 = read.
- req_len_in  in  LW  data byte count, 0..MAX_BYTES (larger values are clamped to MAX_BYTES).
- wr_data_in  in  8  write byte.
- wr_valid_in  in  1  wr_data_in valid.
- wr_ready_out  out  1  one-cycle pulse; write byte consumed when wr_valid_in & wr_ready_out.
- rd_data_out  out  8  received data byte.
- rd_valid_out  out  1  one-cycle pulse; rd_data_out valid. No backpressure.
- status_out  out  8  byte received during the last command byte.
- done_out  out  1  one-cycle pulse at transaction end.
- int_in  in  1  chip interrupt, asynchronous, active-low.
- int_out  out  1  synchronised, active-high interrupt (2-flop synchroniser plus inversion).
- miso_in  in  1  SPI data from chip.
- rst_out  out  1  chip reset, active-high.
- ss_out  out  1  SPI select, active-low.
- sclk_out  out  1  SPI clock, idle low.
- mosi_out  out  1  SPI data to chip.

## Operation
- FSM states: RST_HOLD, IDLE, SETUP, SHIFT, STALL, HOLD, GAP.
- RST_HOLD: entered on rst_in. rst_out=1 for exactly RST_CYCLES clocks after rst_in deasserts, then → IDLE.
- IDLE: req_ready_out=1. On accept, latch addr/write/len and build cmd = {addr, 1'b0, write, 1'b0}. Load cmd into the TX shift register. ss_out drops to 0 the cycle after accept. → SETUP.
- SETUP: CLK_DIV clocks, then → SHIFT.
- SHIFT: sclk_out toggles every CLK_DIV clocks.
  - MISO is sampled at the end of each low half-period, simultaneous with the rising edge.
  - MOSI changes with each falling edge. Bits are shifted MSB first.
  - 8 rising edges = 1 byte.
  - Byte 0 is cmd; its received byte loads status_out after its 8th rising edge.
  - For data bytes on a read, rd_data_out updates and rd_valid_out pulses on the cycle after the 8th rising edge. MOSI sends 0x00 on reads.
- Write byte fetch occurs at the 8th falling edge of the previous byte.
  - If wr_valid_in=1: wr_ready_out pulses and the byte loads.
  - Otherwise → STALL, with sclk_out held low and ss_out held low. Pulse wr_ready_out on the first cycle wr_valid_in=1, then resume SHIFT with a full low half-period before the next rising edge.
- After the last byte's 8th falling edge → HOLD (CLK_DIV clocks, ss_out still 0). Then ss_out=1 and done_out pulses in the same cycle → GAP (CLK_DIV clocks) → IDLE.
- req_len_in=0: only cmd is shifted.
- rst_in in any state: next cycle ss_out=1 and sclk_out=0. Any in-flight byte is discarded with no done_out or rd_valid_out → RST_HOLD.

## Timing
- Reset values: ss_out=1, sclk_out=0, mosi_out=0, rst_out=1, req_ready_out=0, wr_ready_out=0, rd_valid_out=0, done_out=0, status_out=0x00, rd_data_out=0x00, int_out=0.
- The first MOSI bit is valid from the ss_out fall. Each bit spans 2·CLK_DIV clocks.
- Transaction length without stalls: 1 + CLK_DIV·(2 + 16·(len+1)) clocks from accept to done_out. Next accept possible CLK_DIV+1 clocks after done_out.
- int_out lags int_in by 2–3 clocks.

## Test plan
- Reset: hold rst_in 2 cycles → rst_out=1 for exactly 16 clocks after release, then req_ready_out=1; ss_out=1 and sclk_out=0 throughout.
- Write reg 17, len 1, data 0x91 (wr_valid_in held high):
  - MOSI bits captured at rising edges = 0x8A then 0x91.
  - Exactly 16 rising edges; one wr_ready_out pulse.
  - done_out 1+4·34=137 clocks after accept.
- Read reg 3, len 2, chip model drives status 0x5C then 0xA5, 0x3C: status_out=0x5C; rd_valid_out pulses twice with 0xA5, 0x3C; MOSI = 0x18, 0x00, 0x00.
- Write len 2 with wr_valid_in low for 50 clocks before the second byte: sclk_out stays low and ss_out stays low during the stall; no extra edges; the second byte is correct; done_out is delayed accordingly.
- len 0 read, then rst_in asserted mid-byte of a len-3 read: first transaction gives 8 edges and done_out. Second gives ss_out=1 the next cycle, no rd_valid_out or done_out, and rst_out sequence restarts.
- int_in falls → int_out=1 within 3 clocks; int_in rises → int_out=0 within 3 clocks.
